// File: rtl/tap_rec.sv
// rtl/tap_rec.sv - tape-out pulse decoder writing TAP blocks (length + data) into tape RAM.
// Optional macro TAP_REC_CHECKSUM_EN adds a sticky block XOR error flag on state_dbg[3].
module tap_rec #(
    parameter logic [15:0] PILOT_MIN   = 16'd2000,
    parameter logic [15:0] PILOT_MAX   = 16'd2500,
    parameter logic [8:0]  PILOT_COUNT = 9'd256,
    parameter logic [15:0] SYNC_MAX    = 16'd780,
    parameter logic [16:0] BIT_THRESH  = 17'd2565,
    parameter logic [15:0] BIT_MAX     = 16'd2000,
    parameter logic [15:0] TIMEOUT     = 16'd7000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        record,
    input  logic        ear,
    output logic [15:0] tap_address,
    output logic [7:0]  tap_wdata,
    output logic        tap_we,
    output logic [7:0]  blocks,
    output logic        busy,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SEEK   = 4'd1,
        S_ARMED  = 4'd2,
        S_SYNC2  = 4'd3,
        S_DATA   = 4'd4,
        S_FIN    = 4'd5,
        S_LEN_LO = 4'd6,
        S_LEN_HI = 4'd7
    } state_t;

    state_t      state_q, state_d;
    logic        ear_s1_q, ear_s2_q, ear_s3_q;
    logic [15:0] cnt_q;
    logic [8:0]  pilot_n_q, pilot_n_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] base_q, base_d;
    logic [15:0] len_q, len_d;
    logic [2:0]  bitn_q, bitn_d;
    logic        half_q, half_d;
    logic [15:0] h1_q, h1_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  blocks_q, blocks_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
`ifdef TAP_REC_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
    logic        err_q, err_d;
`endif

    logic        edge_det, timeout, is_pilot, bit_val;
    logic [15:0] w;
    logic [16:0] sum;
    logic [7:0]  byte_nxt;

    assign edge_det = ear_s2_q ^ ear_s3_q;
    assign w        = cnt_q;
    assign timeout  = !edge_det && (cnt_q == TIMEOUT);
    assign is_pilot = (w >= PILOT_MIN) && (w <= PILOT_MAX);
    assign sum      = {1'b0, h1_q} + {1'b0, w};
    assign bit_val  = (sum >= BIT_THRESH);
    assign byte_nxt = {shreg_q[6:0], bit_val};

    // Synchronizer plus half-pulse width counter; runs in every state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ear_s1_q <= 1'b0;
            ear_s2_q <= 1'b0;
            ear_s3_q <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            ear_s1_q <= ear;
            ear_s2_q <= ear_s1_q;
            ear_s3_q <= ear_s2_q;
            if (edge_det)
                cnt_q <= 16'd1;
            else if (cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pilot_n_q <= 9'd0;
            ptr_q     <= 16'd0;
            base_q    <= 16'd0;
            len_q     <= 16'd0;
            bitn_q    <= 3'd7;
            half_q    <= 1'b0;
            h1_q      <= 16'd0;
            shreg_q   <= 8'd0;
            blocks_q  <= 8'd0;
            addr_q    <= 16'd0;
            wdata_q   <= 8'd0;
            we_q      <= 1'b0;
`ifdef TAP_REC_CHECKSUM_EN
            xor_q     <= 8'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pilot_n_q <= pilot_n_d;
            ptr_q     <= ptr_d;
            base_q    <= base_d;
            len_q     <= len_d;
            bitn_q    <= bitn_d;
            half_q    <= half_d;
            h1_q      <= h1_d;
            shreg_q   <= shreg_d;
            blocks_q  <= blocks_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
`ifdef TAP_REC_CHECKSUM_EN
            xor_q     <= xor_d;
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pilot_n_d = pilot_n_q;
        ptr_d     = ptr_q;
        base_d    = base_q;
        len_d     = len_q;
        bitn_d    = bitn_q;
        half_d    = half_q;
        h1_d      = h1_q;
        shreg_d   = shreg_q;
        blocks_d  = blocks_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
`ifdef TAP_REC_CHECKSUM_EN
        xor_d     = xor_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (record) begin
                    state_d   = S_SEEK;
                    pilot_n_d = 9'd0;
                end
            end
            S_SEEK: begin
                if (!record)
                    state_d = S_IDLE;
                else if (pilot_n_q >= PILOT_COUNT)
                    state_d = S_ARMED;
                else if (edge_det && is_pilot) begin
                    if (pilot_n_q != 9'h1FF)
                        pilot_n_d = pilot_n_q + 9'd1;
                end else if (edge_det || timeout)
                    pilot_n_d = 9'd0;
            end
            S_ARMED: begin
                if (!record)
                    state_d = S_IDLE;
                else if (edge_det && is_pilot)
                    state_d = S_ARMED;
                else if (edge_det && (w < SYNC_MAX))
                    state_d = S_SYNC2;
                else if (edge_det || timeout) begin
                    state_d   = S_SEEK;
                    pilot_n_d = 9'd0;
                end
            end
            S_SYNC2: begin
                if (!record)
                    state_d = S_IDLE;
                else if (edge_det && (w < SYNC_MAX)) begin
                    state_d = S_DATA;
                    ptr_d   = base_q + 16'd2;
                    len_d   = 16'd0;
                    bitn_d  = 3'd7;
                    half_d  = 1'b0;
`ifdef TAP_REC_CHECKSUM_EN
                    xor_d   = 8'd0;
`endif
                end else if (edge_det || timeout) begin
                    state_d   = S_SEEK;
                    pilot_n_d = 9'd0;
                end
            end
            S_DATA: begin
                if (!record || timeout || (edge_det && (w >= BIT_MAX)))
                    state_d = S_FIN;
                else if (edge_det && !half_q) begin
                    h1_d   = w;
                    half_d = 1'b1;
                end else if (edge_det) begin
                    half_d  = 1'b0;
                    shreg_d = byte_nxt;
                    if (bitn_q == 3'd0) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = byte_nxt;
                        ptr_d   = ptr_q + 16'd1;
                        len_d   = len_q + 16'd1;
                        bitn_d  = 3'd7;
`ifdef TAP_REC_CHECKSUM_EN
                        xor_d   = xor_q ^ byte_nxt;
`endif
                    end else begin
                        bitn_d = bitn_q - 3'd1;
                    end
                end
            end
            S_FIN: begin
                // Any partially shifted byte is dropped simply by never writing it.
                if (len_q == 16'd0) begin
                    ptr_d     = base_q;
                    state_d   = record ? S_SEEK : S_IDLE;
                    pilot_n_d = 9'd0;
                end else begin
                    state_d = S_LEN_LO;
`ifdef TAP_REC_CHECKSUM_EN
                    if (xor_q != 8'd0)
                        err_d = 1'b1;
`endif
                end
            end
            S_LEN_LO: begin
                we_d    = 1'b1;
                addr_d  = base_q;
                wdata_d = len_q[7:0];
                state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                we_d      = 1'b1;
                addr_d    = base_q + 16'd1;
                wdata_d   = len_q[15:8];
                base_d    = ptr_q;
                blocks_d  = blocks_q + 8'd1;
                state_d   = record ? S_SEEK : S_IDLE;
                pilot_n_d = 9'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tap_address = addr_q;
    assign tap_wdata   = wdata_q;
    assign tap_we      = we_q;
    assign blocks      = blocks_q;
    assign busy        = (state_q != S_IDLE);
`ifdef TAP_REC_CHECKSUM_EN
    assign state_dbg   = err_q ? {1'b1, state_q[2:0]} : state_q;
`else
    assign state_dbg   = state_q;
`endif

endmodule

// File: tb/tb_tap_rec.sv
// tb/tb_tap_rec.sv - directed bench for tap_rec; timing constants scaled by 1/8 to keep runs short.
module tb_tap_rec;

    localparam int PW  = 271;
    localparam int S1  = 83;
    localparam int S2  = 92;
    localparam int B0  = 107;
    localparam int B1  = 214;
    localparam int SIL = 1250;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        record = 1'b0;
    logic        ear = 1'b0;
    logic [15:0] tap_address;
    logic [7:0]  tap_wdata;
    logic        tap_we;
    logic [7:0]  blocks;
    logic        busy;
    logic [3:0]  state_dbg;

    int checks = 0;
    int passed = 0;
    logic [23:0] wq[$];

    tap_rec #(
        .PILOT_MIN(16'd250), .PILOT_MAX(16'd312), .PILOT_COUNT(9'd8),
        .SYNC_MAX(16'd97), .BIT_THRESH(17'd320), .BIT_MAX(16'd250), .TIMEOUT(16'd875)
    ) dut (
        .clock(clock), .reset_n(reset_n), .record(record), .ear(ear),
        .tap_address(tap_address), .tap_wdata(tap_wdata), .tap_we(tap_we),
        .blocks(blocks), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (tap_we) wq.push_back({tap_address, tap_wdata});

    task automatic half(input int w);
        repeat (w) @(posedge clock);
        #1 ear = ~ear;
    endtask

    task automatic send_pilot(input int n);
        for (int i = 0; i < n; i++) half(PW);
    endtask

    task automatic send_sync();
        half(S1);
        half(S2);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            half(b[i] ? B1 : B0);
            half(b[i] ? B1 : B0);
        end
    endtask

    task automatic silence();
        repeat (SIL) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (tap_address !== 16'd0) $display("FAIL reset_addr got %h want 0000", tap_address); else passed++;
        checks++; if (tap_wdata !== 8'd0) $display("FAIL reset_wdata got %h want 00", tap_wdata); else passed++;
        checks++; if (tap_we !== 1'b0) $display("FAIL reset_we got %b want 0", tap_we); else passed++;
        checks++; if (blocks !== 8'd0) $display("FAIL reset_blocks got %0d want 0", blocks); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (state_dbg !== 4'd0) $display("FAIL reset_state got %h want 0", state_dbg); else passed++;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_block();
        logic [23:0] exp [5] = '{24'h000200, 24'h0003FF, 24'h0004FF, 24'h000003, 24'h000100};
        logic [23:0] got;
        wq.delete();
        record = 1'b1;
        send_pilot(12);
        send_sync();
        send_bits(8'h00, 8);
        send_bits(8'hFF, 8);
        send_bits(8'hFF, 8);
        silence();
        checks++; if (wq.size() != 5) $display("FAIL single_count got %0d want 5", wq.size()); else passed++;
        for (int i = 0; i < 5; i++) begin
            got = (i < wq.size()) ? wq[i] : 24'hxxxxxx;
            checks++; if (got !== exp[i]) $display("FAIL single_wr%0d got %h want %h", i, got, exp[i]); else passed++;
        end
        checks++; if (blocks !== 8'd1) $display("FAIL single_blocks got %0d want 1", blocks); else passed++;
        checks++; if (state_dbg !== 4'd1) $display("FAIL single_state got %h want 1", state_dbg); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp [3] = '{24'h000742, 24'h000501, 24'h000600};
        logic [23:0] got;
        wq.delete();
        send_pilot(12);
        send_sync();
        send_bits(8'h42, 8);
        silence();
        checks++; if (wq.size() != 3) $display("FAIL b2b_count got %0d want 3", wq.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            got = (i < wq.size()) ? wq[i] : 24'hxxxxxx;
            checks++; if (got !== exp[i]) $display("FAIL b2b_wr%0d got %h want %h", i, got, exp[i]); else passed++;
        end
        checks++; if (blocks !== 8'd2) $display("FAIL b2b_blocks got %0d want 2", blocks); else passed++;
`ifdef TAP_REC_CHECKSUM_EN
        checks++; if (state_dbg !== 4'b1001) $display("FAIL b2b_err got %h want 9", state_dbg); else passed++;
`endif
    endtask

    task automatic test_short_pilot();
        wq.delete();
        send_pilot(4);
        send_sync();
        send_bits(8'h55, 8);
        silence();
        checks++; if (wq.size() != 0) $display("FAIL short_writes got %0d want 0", wq.size()); else passed++;
        checks++; if (state_dbg[2:0] !== 3'd1) $display("FAIL short_state got %h want 1", state_dbg[2:0]); else passed++;
        checks++; if (blocks !== 8'd2) $display("FAIL short_blocks got %0d want 2", blocks); else passed++;
    endtask

    task automatic test_partial();
        logic [23:0] exp [3] = '{24'h000AA5, 24'h000801, 24'h000900};
        logic [23:0] got;
        wq.delete();
        send_pilot(12);
        send_sync();
        send_bits(8'hA8, 5);
        silence();
        checks++; if (wq.size() != 0) $display("FAIL partial_writes got %0d want 0", wq.size()); else passed++;
        checks++; if (blocks !== 8'd2) $display("FAIL partial_blocks got %0d want 2", blocks); else passed++;
        send_pilot(12);
        send_sync();
        send_bits(8'hA5, 8);
        silence();
        checks++; if (wq.size() != 3) $display("FAIL after_partial_count got %0d want 3", wq.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            got = (i < wq.size()) ? wq[i] : 24'hxxxxxx;
            checks++; if (got !== exp[i]) $display("FAIL after_partial_wr%0d got %h want %h", i, got, exp[i]); else passed++;
        end
        checks++; if (blocks !== 8'd3) $display("FAIL after_partial_blocks got %0d want 3", blocks); else passed++;
    endtask

    task automatic test_abort();
        logic [23:0] exp [4] = '{24'h000D12, 24'h000E34, 24'h000B02, 24'h000C00};
        logic [23:0] got;
        wq.delete();
        send_pilot(12);
        send_sync();
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        send_bits(8'hE0, 3);
        record = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        checks++; if (wq.size() != 4) $display("FAIL abort_count got %0d want 4", wq.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            got = (i < wq.size()) ? wq[i] : 24'hxxxxxx;
            checks++; if (got !== exp[i]) $display("FAIL abort_wr%0d got %h want %h", i, got, exp[i]); else passed++;
        end
        checks++; if (blocks !== 8'd4) $display("FAIL abort_blocks got %0d want 4", blocks); else passed++;
        checks++; if (state_dbg[2:0] !== 3'd0) $display("FAIL abort_state got %h want 0", state_dbg[2:0]); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_reset_mid();
        wq.delete();
        record = 1'b1;
        send_pilot(12);
        send_sync();
        send_bits(8'h77, 8);
        send_bits(8'h80, 1);
        repeat (5) @(posedge clock);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (blocks !== 8'd0) $display("FAIL midrst_blocks got %0d want 0", blocks); else passed++;
        checks++; if (tap_address !== 16'd0) $display("FAIL midrst_addr got %h want 0000", tap_address); else passed++;
        checks++; if (state_dbg !== 4'd0) $display("FAIL midrst_state got %h want 0", state_dbg); else passed++;
        record = 1'b0;
        reset_n = 1'b1;
        repeat (SIL) @(posedge clock);
        @(negedge clock);
        checks++; if (wq.size() != 1) $display("FAIL midrst_writes got %0d want 1", wq.size()); else passed++;
        checks++; if (wq.size() > 0 && wq[0] !== 24'h001177) $display("FAIL midrst_wr0 got %h want 001177", wq[0]); else passed++;
    endtask

`ifdef TAP_REC_CHECKSUM_EN
    task automatic test_checksum();
        record = 1'b1;
        send_pilot(12);
        send_sync();
        send_bits(8'h12, 8);
        send_bits(8'h12, 8);
        silence();
        checks++; if (state_dbg !== 4'd1) $display("FAIL csum_zero got %h want 1", state_dbg); else passed++;
        send_pilot(12);
        send_sync();
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        silence();
        checks++; if (state_dbg !== 4'b1001) $display("FAIL csum_err got %h want 9", state_dbg); else passed++;
        checks++; if (blocks !== 8'd2) $display("FAIL csum_blocks got %0d want 2", blocks); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_short_pilot();
        test_partial();
        test_abort();
        test_reset_mid();
`ifdef TAP_REC_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tap_rec.md
Name: tap_rec

Overview:
- Tape recorder for the Spectrum core: the inverse of the TAP player.
- Measures half-period pulse widths on the ULA tape-out line, detects pilot, sync and data bits, and assembles bytes.
- Writes blocks into tape RAM in TAP format: a 2-byte little-endian length, then the data bytes.
- Runs on the 3.5 MHz CPU clock, so every timing constant below is in T-states.

Parameters:
- PILOT_MIN, 2000: shortest half-pulse counted as pilot.
- PILOT_MAX, 2500: longest half-pulse counted as pilot.
- PILOT_COUNT, 256: consecutive pilot half-pulses required to arm sync detection.
- SYNC_MAX, 780: half-pulses shorter than this count as sync.
- BIT_THRESH, 2565: full bit period (two halves) at or above this value decodes as 1, otherwise 0.
- BIT_MAX, 2000: a data half-pulse at or above this value ends the block.
- TIMEOUT, 7000: cycles without an edge that end the block.

Ports:
- clock  in  1  CPU clock, 3.5 MHz.
- reset_n  in  1  synchronous reset, active low.
- record  in  1  recorder enable; 1 = recording.
- ear  in  1  tape signal from the ULA (MIC/EAR out), asynchronous.
- tap_address  out  16  RAM write address.
- tap_wdata  out  8  RAM write data.
- tap_we  out  1  single-cycle write strobe.
- blocks  out  8  completed block count, wraps at 256.
- busy  out  1  high in any state other than IDLE.
- state_dbg  out  4  current state encoding.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-low and applied on posedge clock while reset_n=0.
- Reset values: tap_address=0, tap_wdata=0, tap_we=0, blocks=0, busy=0, state=IDLE. Internal ptr=0, base=0, len=0, err=0.
- Input sampling: ear passes a 2-flop synchronizer, then an edge detector (either polarity). Edge latency is 2-3 cycles.
- Pulse counter: cnt increments every cycle and saturates at 0xFFFF. On an edge, the half-pulse width w=cnt is captured and cnt<=1.
- Timeout: cnt==TIMEOUT with no edge.
- IDLE: waits for record=1, then goes to SEEK with pilot_n=0.
- SEEK:
  - Edge with PILOT_MIN<=w<=PILOT_MAX: pilot_n++ (saturating).
  - Any other edge, or a timeout: pilot_n=0.
  - pilot_n>=PILOT_COUNT: go to ARMED.
- ARMED:
  - Pilot pulses keep it in ARMED.
  - w<SYNC_MAX: go to SYNC2.
  - Any other width, or a timeout: back to SEEK with pilot_n=0.
- SYNC2:
  - w<SYNC_MAX: go to DATA with ptr=base+2, len=0, bitn=7, half=0.
  - Otherwise: back to SEEK.
- DATA:
  - Half-pulses pair up: the first is stored as h1, the second forms h1+w as a 17-bit sum.
  - Bit value is (sum>=BIT_THRESH). Bits are shifted in MSB first.
  - After 8 bits: one cycle with tap_we=1, tap_address=ptr, tap_wdata=byte; then ptr++ and len++ (both mod 2^16).
  - Any w>=BIT_MAX, a timeout, or record=0 ends the block and goes to FIN.
- FIN:
  - A partial byte (fewer than 8 bits) is discarded.
  - len==0: no writes, ptr=base, go to SEEK (or IDLE if record=0).
  - len>0: go to LEN_LO.
- LEN_LO: tap_we=1, tap_address=base, tap_wdata=len[7:0].
- LEN_HI:
  - tap_we=1, tap_address=base+1, tap_wdata=len[15:8].
  - Then base<=ptr, blocks++, and go to SEEK (or IDLE if record=0).
- Write timing: at most one write per cycle. A byte write and the length writes never coincide.
- Address rule: tap_address is driven with the write address only in cycles where tap_we=1. Otherwise it holds its last value.
- record=0 in SEEK, ARMED or SYNC2: go to IDLE the next cycle. base is kept, so the next recording appends.
- An edge that arrives during LEN_LO or LEN_HI still updates cnt; the pulse itself is not classified.
- reset_n=0 mid-block: everything returns to reset values and no length is written.

Optional Feature:
- Macro: TAP_REC_CHECKSUM_EN.
- When defined: a running XOR of all written data bytes of the block is kept. At FIN with len>0, if the XOR is nonzero a sticky err bit is set, cleared only by reset. err is driven on state_dbg[3] in place of the state MSB while err=1. The block is still stored.
- When undefined: no checksum logic; state_dbg carries the full state.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> all outputs 0, state_dbg=IDLE, busy=0.
- Single block:
  - Stimulus: record=1; 300 pilot halves of 2168; syncs 667/735; bytes 0x00,0xFF,0xFF (each bit two halves of 855 or 1710); 10000-cycle silence.
  - Required writes: 0x00@2, 0xFF@3, 0xFF@4, then 0x03@0, 0x00@1; blocks=1; base=5.
- Two blocks back-to-back: second block of 1 byte 0x42 -> writes 0x42@7, 0x01@5, 0x00@6; blocks=2.
- Short pilot: only 100 pilot halves, then sync and data -> no tap_we, state stays in SEEK.
- Partial/empty block:
  - Sync followed by 5 bits, then silence -> no writes, blocks unchanged.
  - Next valid block still starts its length at the old base.
- Abort and checksum:
  - record=0 mid-byte after 2 full bytes 0x12,0x34 -> length 0x0002 written, then IDLE.
  - With TAP_REC_CHECKSUM_EN: bytes 0x12,0x34 give XOR 0x26 -> err=1; bytes 0x12,0x12 -> err stays 0.
